// File: rtl/alu_pkg.sv
// Shared constants for the registered ALU: default width, opcode encodings
// and the bit positions inside KEY.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NOT  = 4'b0101;
  localparam logic [3:0] OP_NAND = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b0111;
  localparam logic [3:0] OP_SHL  = 4'b1000;
  localparam logic [3:0] OP_SHR  = 4'b1001;
  localparam logic [3:0] OP_ROL  = 4'b1010;
  localparam logic [3:0] OP_ROR  = 4'b1011;
  localparam logic [3:0] OP_INC  = 4'b1100;
  localparam logic [3:0] OP_DEC  = 4'b1101;
  localparam logic [3:0] OP_SLT  = 4'b1110;
  localparam logic [3:0] OP_MUL  = 4'b1111;

  // KEY[KEY_CIN] is carry-in / shift fill; KEY[KEY_SGN] picks arithmetic SHR and signed SLT.
  localparam int KEY_CIN = 0;
  localparam int KEY_SGN = 1;

endpackage

// File: rtl/alu_datapath.sv
// Purely combinational ALU core: maps opcode, operands and KEY to the next
// result. All arithmetic wraps modulo 2^WIDTH; carries and overflow are dropped.
module alu_datapath
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [3:0]       OPT,
  input  logic [WIDTH-1:0] RGA,
  input  logic [WIDTH-1:0] RGB,
  input  logic [1:0]       KEY,
  output logic [WIDTH-1:0] res
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] cin;
  logic             fill;
  logic             slt;

  assign cin  = WIDTH'(KEY[KEY_CIN]);
  assign fill = KEY[KEY_SGN] ? RGA[WIDTH-1] : KEY[KEY_CIN];
  assign slt  = KEY[KEY_SGN] ? ($signed(RGA) < $signed(RGB)) : (RGA < RGB);

  always_comb begin
    // NOTE: default assignment before the case guarantees no latch is inferred,
    // even if an opcode arm is later edited out.
    res = '0;
    case (OPT)
      OP_ADD:  res = RGA + RGB + cin;
      OP_SUB:  res = RGA - RGB - cin;
      OP_AND:  res = RGA & RGB;
      OP_OR:   res = RGA | RGB;
      OP_XOR:  res = RGA ^ RGB;
      OP_NOT:  res = ~RGA;
      OP_NAND: res = ~(RGA & RGB);
      OP_NOR:  res = ~(RGA | RGB);
      OP_SHL:  res = {RGA[WIDTH-2:0], KEY[KEY_CIN]};
      OP_SHR:  res = {fill, RGA[WIDTH-1:1]};
      OP_ROL:  res = {RGA[WIDTH-2:0], RGA[WIDTH-1]};
      OP_ROR:  res = {RGA[0], RGA[WIDTH-1:1]};
      OP_INC:  res = RGA + ONE;
      OP_DEC:  res = RGA - ONE;
      OP_SLT:  res = slt ? ONE : '0;
      OP_MUL:  res = RGA * RGB;
    endcase
  end

endmodule

// File: rtl/alu.sv
// Registered ALU top: the combinational datapath feeds RGZ, which loads on
// enabled rising edges and clears asynchronously while RST is low.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ENA,
  input  logic [WIDTH-1:0] RGA,
  input  logic [WIDTH-1:0] RGB,
  input  logic [1:0]       KEY,
  input  logic [3:0]       OPT,
  output logic [WIDTH-1:0] RGZ
);

  logic [WIDTH-1:0] nxt;

  alu_datapath #(.WIDTH(WIDTH)) u_datapath (
    .OPT (OPT),
    .RGA (RGA),
    .RGB (RGB),
    .KEY (KEY),
    .res (nxt)
  );

  always_ff @(posedge CLK or negedge RST) begin
    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    if (!RST) begin
      RGZ <= '0;
    end else if (ENA) begin
      RGZ <= nxt;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: reset/hold sequences, a directed vector table,
// a pipelined ADD stream, mid-stream async reset and randomized traffic.
module tb_alu;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b0;
  logic [7:0] rga = '0;
  logic [7:0] rgb = '0;
  logic [1:0] key = '0;
  logic [3:0] opt = '0;
  logic [7:0] rgz;

  int n_total = 0;
  int n_pass  = 0;

  alu #(.WIDTH(8)) dut (
    .CLK (clk),
    .RST (rst),
    .ENA (ena),
    .RGA (rga),
    .RGB (rgb),
    .RGZ (rgz),
    .KEY (key),
    .OPT (opt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] k;
    logic [7:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model from the opcode definitions, using plain integer arithmetic.
  function automatic logic [7:0] ref_alu(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic [1:0] k);
    int ia, ib, cin, r, sa, sb;
    ia = int'(a); ib = int'(b); cin = int'(k[0]);
    sa = (ia >= 128) ? ia - 256 : ia;
    sb = (ib >= 128) ? ib - 256 : ib;
    case (op)
      4'd0:  r = (ia + ib + cin) % 256;
      4'd1:  r = (ia - ib - cin + 512) % 256;
      4'd2:  r = ia & ib;
      4'd3:  r = ia | ib;
      4'd4:  r = ia ^ ib;
      4'd5:  r = 255 - ia;
      4'd6:  r = 255 - (ia & ib);
      4'd7:  r = 255 - (ia | ib);
      4'd8:  r = (ia * 2 + cin) % 256;
      4'd9:  r = ia / 2 + ((k[1] ? (ia / 128) : cin) * 128);
      4'd10: r = (ia * 2) % 256 + ia / 128;
      4'd11: r = ia / 2 + (ia % 2) * 128;
      4'd12: r = (ia + 1) % 256;
      4'd13: r = (ia + 255) % 256;
      4'd14: r = k[1] ? ((sa < sb) ? 1 : 0) : ((ia < ib) ? 1 : 0);
      default: r = (ia * ib) % 256;
    endcase
    return 8'(r);
  endfunction

  // Drive on the falling edge, let the rising edge load, sample 1 time unit later.
  task automatic step(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [1:0] k, input logic en);
    @(negedge clk);
    opt = op; rga = a; rgb = b; key = k; ena = en;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    logic [7:0] held;
    logic [7:0] exp_q;
    logic [7:0] add_in [4];
    logic [7:0] add_out [4];

    vecs.push_back('{"add_wrap",  4'b0000, 8'hFF, 8'h00, 2'b01, 8'h00});
    vecs.push_back('{"add_plain", 4'b0000, 8'h10, 8'h20, 2'b00, 8'h30});
    vecs.push_back('{"sub_wrap",  4'b0001, 8'h00, 8'h01, 2'b00, 8'hFF});
    vecs.push_back('{"and",       4'b0010, 8'h96, 8'h0F, 2'b00, 8'h06});
    vecs.push_back('{"or",        4'b0011, 8'hF0, 8'h0F, 2'b00, 8'hFF});
    vecs.push_back('{"xor",       4'b0100, 8'hFF, 8'h0F, 2'b00, 8'hF0});
    vecs.push_back('{"not",       4'b0101, 8'h96, 8'h00, 2'b00, 8'h69});
    vecs.push_back('{"nand",      4'b0110, 8'hF0, 8'h3C, 2'b00, 8'hCF});
    vecs.push_back('{"nor",       4'b0111, 8'hF0, 8'h0C, 2'b00, 8'h03});
    vecs.push_back('{"shl",       4'b1000, 8'h96, 8'h00, 2'b00, 8'h2C});
    vecs.push_back('{"shr_arith", 4'b1001, 8'h96, 8'h00, 2'b10, 8'hCB});
    vecs.push_back('{"shr_fill",  4'b1001, 8'h96, 8'h00, 2'b01, 8'hCB});
    vecs.push_back('{"shr_zero",  4'b1001, 8'h96, 8'h00, 2'b00, 8'h4B});
    vecs.push_back('{"rol",       4'b1010, 8'h96, 8'h00, 2'b00, 8'h2D});
    vecs.push_back('{"ror",       4'b1011, 8'h96, 8'h00, 2'b00, 8'h4B});
    vecs.push_back('{"inc_wrap",  4'b1100, 8'hFF, 8'h00, 2'b00, 8'h00});
    vecs.push_back('{"dec_wrap",  4'b1101, 8'h00, 8'h00, 2'b00, 8'hFF});
    vecs.push_back('{"slt_uns",   4'b1110, 8'hFE, 8'h01, 2'b00, 8'h00});
    vecs.push_back('{"slt_sgn",   4'b1110, 8'hFE, 8'h01, 2'b10, 8'h01});
    vecs.push_back('{"mul",       4'b1111, 8'h12, 8'h10, 2'b00, 8'h20});

    add_in  = '{8'h07, 8'h05, 8'h06, 8'h02};
    add_out = '{8'h08, 8'h06, 8'h07, 8'h03};

    // Asynchronous reset with no clock edge in between.
    rga = 8'h07; opt = 4'b0000; ena = 1'b1;
    #2 rst = 1'b0;
    #1 check("reset_async", rgz, 8'h00);
    @(posedge clk); #1;
    check("reset_held", rgz, 8'h00);
    @(negedge clk) rst = 1'b1;

    // Pipelined ADD stream: each result appears one edge after its operand.
    for (int i = 0; i < 4; i++) begin
      step(4'b0000, add_in[i], 8'h00, 2'b01, 1'b1);
      check($sformatf("add_stream_%0d", i), rgz, add_out[i]);
    end

    // Hold with ENA=0 while operands keep changing.
    held = rgz;
    for (int i = 0; i < 3; i++) begin
      step(4'b0101, 8'h3C + 8'(i), 8'h11, 2'b11, 1'b0);
      check($sformatf("hold_%0d", i), rgz, held);
    end

    // Directed vector table, checked against table constants and the model.
    foreach (vecs[i]) begin
      step(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].k, 1'b1);
      check(vecs[i].name, rgz, vecs[i].exp);
      check({vecs[i].name, "_model"}, rgz, ref_alu(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].k));
    end

    // Operand changes between edges leave RGZ alone until the next enabled edge.
    step(4'b1111, 8'h03, 8'h05, 2'b00, 1'b1);
    @(negedge clk); rga = 8'hAA; opt = 4'b0011;
    #2 check("no_mid_cycle_effect", rgz, 8'h0F);

    // Reset dropped between edges while enabled, then released.
    step(4'b0000, 8'h40, 8'h02, 2'b00, 1'b1);
    check("pre_reset_load", rgz, 8'h42);
    #2 rst = 1'b0;
    #1 check("reset_mid_stream", rgz, 8'h00);
    @(posedge clk); #1;
    check("reset_mid_held", rgz, 8'h00);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("post_release_load", rgz, 8'h42);

    // Randomized traffic with a tracked expected register value.
    exp_q = rgz;
    for (int i = 0; i < 300; i++) begin
      logic [3:0] op;
      logic [7:0] a, b;
      logic [1:0] k;
      logic       en;
      op = 4'($urandom_range(0, 15));
      a  = 8'($urandom);
      b  = 8'($urandom);
      k  = 2'($urandom);
      en = ($urandom_range(0, 7) != 0);
      step(op, a, b, k, en);
      if (en) exp_q = ref_alu(op, a, b, k);
      check($sformatf("rand_%0d_op%0d", i, op), rgz, exp_q);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
